// File: rtl/video_io_regs.sv
// ISA I/O register front end for the CGA/Tandy video path: port decode, mode/colour/palette registers, read mux, blink.
// Optional ISA wait-state generator enabled by defining VIDEO_IO_WAIT_EN.
module video_io_regs #(
  parameter logic [15:0] IO_BASE_ADDR       = 16'h3D0,
  parameter logic [23:0] BLINK_MAX          = 24'd0,
  parameter int unsigned PAL_ENTRIES        = 16,
  parameter logic [7:0]  CTRL_RESET         = 8'h29,
  parameter int unsigned WAIT_CYCLES        = 3,
  parameter bit          NO_DISPLAY_DISABLE = 1'b0,
  localparam int unsigned PAL_AW = (PAL_ENTRIES > 1) ? $clog2(PAL_ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [14:0]       bus_a,
  input  logic              bus_ior_l,
  input  logic              bus_iow_l,
  input  logic              bus_aen,
  input  logic [7:0]        bus_d,
  output logic [7:0]        bus_out,
  output logic              bus_dir,
  output logic              bus_rdy,
  input  logic [7:0]        crtc_bus_out,
  output logic              crtc_cs,
  output logic              crtc_wr,
  output logic              crtc_rd,
  input  logic              vsync_l,
  input  logic              display_enable,
  input  logic              blink_hold,
  output logic              hres_mode,
  output logic              grph_mode,
  output logic              bw_mode,
  output logic              mode_640,
  output logic              blink_enabled,
  output logic              video_enabled,
  output logic [7:0]        color_reg,
  output logic              blink,
  output logic              pal_we,
  output logic [PAL_AW-1:0] pal_addr,
  output logic [3:0]        pal_data
);

  localparam logic [3:0] OFF_CTRL  = 4'h8;
  localparam logic [3:0] OFF_COLOR = 4'h9;
  localparam logic [3:0] OFF_INDEX = 4'hA;
  localparam logic [3:0] OFF_PDATA = 4'hE;
  localparam logic [8:0] PAL_LO    = 9'h010;
  localparam logic [8:0] PAL_HI    = 9'(16 + PAL_ENTRIES);

  logic              iow_s1_q, iow_s1_d, iow_s2_q, iow_s2_d, iow_prev_q, iow_prev_d;
  logic              ior_s1_q, ior_s1_d, ior_s2_q, ior_s2_d;
  logic [7:0]        ctrl_q, ctrl_d, color_q, color_d, idx_q, idx_d;
  logic [23:0]       blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic              pal_we_q, pal_we_d, crtc_wr_q, crtc_wr_d;
  logic [PAL_AW-1:0] pal_addr_q, pal_addr_d;
  logic [3:0]        pal_data_q, pal_data_d;

  logic       win_sel_c, status_sel_c, wr_edge_c, pal_hit_c;
  logic [3:0] offset_c;
  logic [7:0] status_c;

  assign offset_c     = bus_a[3:0];
  assign win_sel_c    = ~bus_aen & (bus_a[14:4] == IO_BASE_ADDR[14:4]);
  assign crtc_cs      = win_sel_c & ~offset_c[3];
  assign status_sel_c = win_sel_c & (offset_c == OFF_INDEX);
  assign wr_edge_c    = iow_prev_q & ~iow_s2_q;
  assign pal_hit_c    = ({1'b0, idx_q} >= PAL_LO) && ({1'b0, idx_q} < PAL_HI);
  assign status_c     = {4'b1111, vsync_l, 2'b10, ~display_enable};

  // Next-state for synchronisers, registers, palette/CRTC pulses and blink.
  always_comb begin
    iow_s1_d    = bus_iow_l;
    iow_s2_d    = iow_s1_q;
    iow_prev_d  = iow_s2_q;
    ior_s1_d    = bus_ior_l;
    ior_s2_d    = ior_s1_q;
    ctrl_d      = ctrl_q;
    color_d     = color_q;
    idx_d       = idx_q;
    pal_addr_d  = pal_addr_q;
    pal_data_d  = pal_data_q;
    pal_we_d    = 1'b0;
    crtc_wr_d   = 1'b0;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;

    if (wr_edge_c) begin
      crtc_wr_d = crtc_cs;
      if (win_sel_c) begin
        case (offset_c)
          OFF_CTRL:  ctrl_d  = bus_d;
          OFF_COLOR: color_d = bus_d;
          OFF_INDEX: idx_d   = bus_d;
          OFF_PDATA: begin
            if (pal_hit_c) begin
              pal_we_d   = 1'b1;
              pal_addr_d = PAL_AW'(idx_q - 8'h10);
              pal_data_d = bus_d[3:0];
            end
          end
          default: ;
        endcase
      end
    end

    if (!blink_hold) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = 24'(blink_cnt_q + 24'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iow_s1_q    <= 1'b1;
      iow_s2_q    <= 1'b1;
      iow_prev_q  <= 1'b1;
      ior_s1_q    <= 1'b1;
      ior_s2_q    <= 1'b1;
      ctrl_q      <= CTRL_RESET;
      color_q     <= '0;
      idx_q       <= '0;
      pal_addr_q  <= '0;
      pal_data_q  <= '0;
      pal_we_q    <= 1'b0;
      crtc_wr_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      iow_s1_q    <= iow_s1_d;
      iow_s2_q    <= iow_s2_d;
      iow_prev_q  <= iow_prev_d;
      ior_s1_q    <= ior_s1_d;
      ior_s2_q    <= ior_s2_d;
      ctrl_q      <= ctrl_d;
      color_q     <= color_d;
      idx_q       <= idx_d;
      pal_addr_q  <= pal_addr_d;
      pal_data_q  <= pal_data_d;
      pal_we_q    <= pal_we_d;
      crtc_wr_q   <= crtc_wr_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // Read data follows the raw strobe so the bus sees it within the ISA cycle.
  always_comb begin
    bus_out = 8'h00;
    bus_dir = (crtc_cs | status_sel_c) & ~bus_ior_l;
    if (!bus_ior_l) begin
      if (status_sel_c)              bus_out = status_c;
      else if (crtc_cs && bus_a[0])  bus_out = crtc_bus_out;
    end
  end

  assign crtc_rd       = ~ior_s2_q;
  assign crtc_wr       = crtc_wr_q;
  assign hres_mode     = ctrl_q[0];
  assign grph_mode     = ctrl_q[1];
  assign bw_mode       = ctrl_q[2];
  assign video_enabled = ctrl_q[3] | NO_DISPLAY_DISABLE;
  assign mode_640      = ctrl_q[4];
  assign blink_enabled = ctrl_q[5];
  assign color_reg     = color_q;
  assign blink         = blink_q;
  assign pal_we        = pal_we_q;
  assign pal_addr      = pal_addr_q;
  assign pal_data      = pal_data_q;

`ifdef VIDEO_IO_WAIT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       rdy_q, rdy_d, ior_prev_q, ior_prev_d;
  logic       rd_edge_c, decoded_c;

  assign rd_edge_c = ior_prev_q & ~ior_s2_q;
  assign decoded_c = win_sel_c & (~offset_c[3] | (offset_c == OFF_CTRL) | (offset_c == OFF_COLOR)
                                  | (offset_c == OFF_INDEX) | (offset_c == OFF_PDATA));

  // Hold bus_rdy low for WAIT_CYCLES after each accepted access, then wait for strobes to clear.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rdy_d      = rdy_q;
    ior_prev_d = ior_s2_q;
    case (state_q)
      ST_IDLE: begin
        if ((wr_edge_c | rd_edge_c) && decoded_c) begin
          state_d = ST_WAIT;
          wcnt_d  = 4'(WAIT_CYCLES - 1);
          rdy_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = ST_DONE;
          rdy_d   = 1'b1;
        end else begin
          wcnt_d = 4'(wcnt_q - 4'd1);
        end
      end
      ST_DONE: begin
        if (iow_s2_q && ior_s2_q) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      rdy_q      <= 1'b1;
      ior_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rdy_q      <= rdy_d;
      ior_prev_q <= ior_prev_d;
    end
  end

  assign bus_rdy = rdy_q;
`else
  assign bus_rdy = 1'b1;
`endif

endmodule

// File: tb/tb_video_io_regs.sv
// Randomised scoreboard bench for video_io_regs; palette and CRTC write pulses are checked by a monitor process.
module tb_video_io_regs;
  localparam logic [23:0] BM = 24'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] bus_a;
  logic        bus_ior_l, bus_iow_l, bus_aen;
  logic [7:0]  bus_d, bus_out, crtc_bus_out, color_reg;
  logic        bus_dir, bus_rdy, crtc_cs, crtc_wr, crtc_rd;
  logic        vsync_l, display_enable, blink_hold;
  logic        hres_mode, grph_mode, bw_mode, mode_640, blink_enabled, video_enabled, blink, pal_we;
  logic [3:0]  pal_addr, pal_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] ctrl_m, color_m, idx_m;
  logic [7:0] pal_q[$];
  logic       crtc_q[$];
  int         unheld = 0;
  logic       blink_chk_en = 1'b0;

  video_io_regs #(
    .IO_BASE_ADDR(16'h3D0), .BLINK_MAX(BM), .PAL_ENTRIES(16),
    .CTRL_RESET(8'h29), .WAIT_CYCLES(3), .NO_DISPLAY_DISABLE(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .bus_a(bus_a), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
    .bus_aen(bus_aen), .bus_d(bus_d), .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
    .crtc_bus_out(crtc_bus_out), .crtc_cs(crtc_cs), .crtc_wr(crtc_wr), .crtc_rd(crtc_rd),
    .vsync_l(vsync_l), .display_enable(display_enable), .blink_hold(blink_hold),
    .hres_mode(hres_mode), .grph_mode(grph_mode), .bw_mode(bw_mode), .mode_640(mode_640),
    .blink_enabled(blink_enabled), .video_enabled(video_enabled), .color_reg(color_reg),
    .blink(blink), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Blink reference: phase is the count of unheld clocks divided into half-periods of BM+1.
  always @(posedge clk) begin
    if (reset) unheld = 0;
    else if (!blink_hold) unheld = unheld + 1;
  end

  // Monitor: pops expected pulses whenever the DUT emits one.
  always @(negedge clk) begin
    if (!reset) begin
      if (pal_we) begin
        if (pal_q.size() == 0) chk("pal_we_unexpected", {pal_addr, pal_data}, 32'hFFFF_FFFF);
        else chk("pal_entry", {24'b0, pal_addr, pal_data}, {24'b0, pal_q.pop_front()});
      end
      if (crtc_wr) begin
        if (crtc_q.size() == 0) chk("crtc_wr_unexpected", 32'(crtc_wr), 32'd0);
        else begin
          void'(crtc_q.pop_front());
          chk("crtc_wr_cs", 32'(crtc_cs), 32'd1);
        end
      end
      if (blink_chk_en) chk("blink", 32'(blink), 32'((unheld / (int'(BM) + 1)) % 2));
    end
  end

  task automatic model_reset();
    ctrl_m = 8'h29; color_m = 8'h00; idx_m = 8'h00;
  endtask

  task automatic chk_regs();
    chk("ctrl", {26'b0, blink_enabled, mode_640, video_enabled, bw_mode, grph_mode, hres_mode},
        {26'b0, ctrl_m[5:0]});
    chk("color", 32'(color_reg), 32'(color_m));
  endtask

  task automatic model_write(input logic [14:0] a, input logic [7:0] d, input logic aen);
    logic [3:0] off;
    off = a[3:0];
    if (!aen && a[14:4] == 11'h03D) begin
      if (off < 4'h8) crtc_q.push_back(1'b1);
      else case (off)
        4'h8: ctrl_m  = d;
        4'h9: color_m = d;
        4'hA: idx_m   = d;
        4'hE: if (idx_m >= 8'h10 && idx_m < 8'h20) pal_q.push_back({4'(idx_m - 8'h10), d[3:0]});
        default: ;
      endcase
    end
  endtask

  task automatic io_write(input logic [14:0] a, input logic [7:0] d, input logic aen);
    model_write(a, d, aen);
    @(negedge clk); bus_a = a; bus_d = d; bus_aen = aen; bus_iow_l = 1'b0;
    repeat (6) @(negedge clk);
    bus_iow_l = 1'b1;
    repeat (4) @(negedge clk);
    bus_aen = 1'b0;
    chk_regs();
  endtask

  task automatic io_read(input logic [14:0] a, input logic aen, input logic vs, input logic de,
                         input logic [7:0] cd);
    logic win, st, cs;
    logic [7:0] exp_d;
    @(negedge clk);
    bus_a = a; bus_aen = aen; vsync_l = vs; display_enable = de; crtc_bus_out = cd; bus_ior_l = 1'b0;
    #1;
    win = !aen && a[14:4] == 11'h03D;
    st  = win && a[3:0] == 4'hA;
    cs  = win && a[3:0] < 4'h8;
    exp_d = st ? {4'b1111, vs, 2'b10, ~de} : (cs && a[0]) ? cd : 8'h00;
    chk("rd_data", 32'(bus_out), 32'(exp_d));
    chk("rd_dir", 32'(bus_dir), 32'(st | cs));
    repeat (2) @(negedge clk);
    chk("crtc_rd_level", 32'(crtc_rd), 32'd1);
`ifndef VIDEO_IO_WAIT_EN
    chk("bus_rdy_tied", 32'(bus_rdy), 32'd1);
`endif
    bus_ior_l = 1'b1;
    repeat (6) @(negedge clk);
    chk("crtc_rd_idle", 32'(crtc_rd), 32'd0);
    bus_aen = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] off;
    logic [14:0] a;
    logic [7:0] d;
    logic b0;
    reset = 1'b1; bus_a = '0; bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_aen = 1'b0; bus_d = '0;
    crtc_bus_out = '0; vsync_l = 1'b1; display_enable = 1'b0; blink_hold = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Reset state
    chk_regs();
    chk("rst_hres", 32'(hres_mode), 32'd1);
    chk("rst_video", 32'(video_enabled), 32'd1);
    chk("rst_blink_en", 32'(blink_enabled), 32'd1);
    chk("rst_rdy", 32'(bus_rdy), 32'd1);
    chk("rst_pal_we", 32'(pal_we), 32'd0);
    chk("rst_blink", 32'(blink), 32'd0);

    // OUT 3D8 with 3-clock latency and a long strobe
    model_write(15'h3D8, 8'h1A, 1'b0);
    bus_a = 15'h3D8; bus_d = 8'h1A; bus_iow_l = 1'b0;
    repeat (2) @(negedge clk);
    chk("ctrl_before_latency", 32'(ctrl_check()), 32'h29);
    @(negedge clk);
    chk("ctrl_at_latency", 32'(ctrl_check()), 32'h1A);
    repeat (7) @(negedge clk);
    bus_iow_l = 1'b1;
    repeat (4) @(negedge clk);
    chk_regs();
    chk("grph", 32'(grph_mode), 32'd1);
    chk("m640", 32'(mode_640), 32'd1);
    chk("hres_off", 32'(hres_mode), 32'd0);

    // Ignored ports, DMA cycles, palette boundaries
    io_write(15'h3DF, 8'h55, 1'b0);
    io_write(15'h3D8, 8'h3F, 1'b1);
    io_write(15'h3B8, 8'h00, 1'b0);
    io_write(15'h3DA, 8'h13, 1'b0);
    io_write(15'h3DE, 8'h07, 1'b0);
    io_write(15'h3DA, 8'h25, 1'b0);
    io_write(15'h3DE, 8'h09, 1'b0);
    io_write(15'h3DA, 8'h10, 1'b0);
    io_write(15'h3DE, 8'hFC, 1'b0);
    io_write(15'h3DA, 8'h1F, 1'b0);
    io_write(15'h3DE, 8'h05, 1'b0);
    io_write(15'h3DA, 8'h0F, 1'b0);
    io_write(15'h3DE, 8'h06, 1'b0);
    io_write(15'h3DA, 8'h20, 1'b0);
    io_write(15'h3DE, 8'h0B, 1'b0);
    io_write(15'h3D4, 8'h0E, 1'b0);
    io_write(15'h3D9, 8'hA5, 1'b0);

    // Directed reads
    io_read(15'h3DA, 1'b0, 1'b0, 1'b1, 8'h00);
    io_read(15'h3D5, 1'b0, 1'b1, 1'b0, 8'hA5);
    io_read(15'h3D4, 1'b0, 1'b1, 1'b0, 8'h3C);
    io_read(15'h3DA, 1'b1, 1'b1, 1'b0, 8'h11);

    // Blink period and hold
    blink_chk_en = 1'b1;
    repeat (12) @(negedge clk);
    b0 = blink;
    blink_hold = 1'b1;
    repeat (10) @(negedge clk);
    chk("blink_hold", 32'(blink), 32'(b0));
    blink_hold = 1'b0;
    repeat (12) @(negedge clk);
    blink_chk_en = 1'b0;

    // Random writes and reads
    for (int i = 0; i < 60; i++) begin
      off = 4'($urandom_range(0, 15));
      a   = ($urandom_range(0, 9) == 0) ? {11'h03B, off} : {11'h03D, off};
      d   = (off == 4'hA) ? 8'($urandom_range(8'h0C, 8'h24)) : 8'($urandom);
      io_write(a, d, $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 20; i++) begin
      off = 4'($urandom_range(0, 15));
      io_read({11'h03D, off}, $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 8'($urandom));
    end

`ifdef VIDEO_IO_WAIT_EN
    @(negedge clk); bus_a = 15'h3DA; bus_ior_l = 1'b0;
    repeat (2) @(negedge clk);
    chk("rdy_before_wait", 32'(bus_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rdy_wait_low", 32'(bus_rdy), 32'd0);
    end
    @(negedge clk);
    chk("rdy_after_wait", 32'(bus_rdy), 32'd1);
    bus_ior_l = 1'b1;
    repeat (6) @(negedge clk);
    bus_ior_l = 1'b0;
    repeat (3) @(negedge clk);
    chk("rdy_wait_before_reset", 32'(bus_rdy), 32'd0);
    reset = 1'b1; bus_ior_l = 1'b1;
    @(negedge clk);
    chk("rdy_reset_in_wait", 32'(bus_rdy), 32'd1);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_regs();
`endif

    repeat (5) @(negedge clk);
    chk("pal_q_drained", pal_q.size(), 0);
    chk("crtc_q_drained", crtc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [7:0] ctrl_check();
    return {2'b00, blink_enabled, mode_640, video_enabled, bw_mode, grph_mode, hres_mode};
  endfunction

endmodule
